ram_sdp_lanes: RTL and testbench
================================

Name: ram_sdp_lanes

Overview:
- Simple-dual-port vector RAM: one write port and one read port per cycle.
- Per-lane write mask, configurable read latency and a read-valid strobe.
- Write-first forwarding when the read and write addresses collide.
- Sequential clear engine replaces the all-at-once reset clear.
- Serves as the activation/weight buffer feeding the transformer datapath, where producers write partial lanes while consumers stream reads.

Parameters:
- LANES, 33, number of independently maskable lanes per word
- LANE_WIDTH, 8, bits per lane
- VEC_WIDTH, LANES*LANE_WIDTH (264), word width; derived, not overridden
- ARR_DEPTH, 2048, words in the array
- ADDR_WIDTH, $clog2(ARR_DEPTH), address width; derived
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 only

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  start a full-array clear (pulse)
- o_busy  out  1  clear in progress; all accesses ignored
- i_we  in  1  write enable
- i_waddr  in  ADDR_WIDTH  write address
- i_wmask  in  LANES  lane write enables; bit k covers bits [k*LANE_WIDTH +: LANE_WIDTH]
- i_wdata  in  VEC_WIDTH  write data
- i_re  in  1  read enable
- i_raddr  in  ADDR_WIDTH  read address
- o_rvalid  out  1  o_rdata valid this cycle
- o_rdata  out  VEC_WIDTH  read data

Behaviour:
- Reset: one clock i_clk; reset i_rst_n is asynchronous and active-low. Reset values:
  - state=CLEAR, clear pointer=0, o_busy=1
  - o_rvalid=0, o_rdata=0, all read-pipeline registers 0
  - Array contents are NOT reset directly; the clear engine zeroes them.
- FSM states:
  - IDLE -> CLEAR when i_clr=1.
  - CLEAR: writes 0 to mem[ptr] and increments ptr each cycle. When ptr=ARR_DEPTH-1 is written, go to IDLE and reset ptr to 0.
  - o_busy = (state==CLEAR). After reset release, o_busy stays high for exactly ARR_DEPTH cycles.
  - i_clr while in CLEAR restarts ptr at 0, so the clear runs another full ARR_DEPTH cycles.
- While o_busy=1: i_we and i_re are ignored (no write, no new read issued).
  - Reads issued before CLEAR entry still complete and pulse o_rvalid normally.
- i_clr and i_we in the same IDLE cycle: clear wins, the write is dropped, and CLEAR is entered next cycle.
- Write: on a rising edge with i_we=1, lanes with i_wmask[k]=1 take i_wdata; other lanes keep their value. An all-zero i_wmask is a no-op.
- Read:
  - READ_LAT=1: i_re at edge N -> o_rdata and o_rvalid=1 after edge N.
  - READ_LAT=2: an extra output register; valid after edge N+1.
  - o_rvalid is high for exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
  - o_rdata holds its last value when o_rvalid=0.
- Collision (i_re, i_we, i_raddr==i_waddr in the same cycle): write-first. Returned lanes = new data where i_wmask=1, old contents elsewhere.
- Addresses are full-range, so there is no out-of-range case.
- Asserting reset mid-clear or mid-read aborts the operation; the block returns to reset values and restarts CLEAR.

Decomposition:
- Package ram_pkg:
  - default LANES, LANE_WIDTH, ARR_DEPTH
  - READ_LAT legality check constant
  - lane-mask expansion function (LANES -> VEC_WIDTH bit mask)
- One natural sub-module, ram_clr_ctrl: clear FSM, pointer, o_busy, clear write-port override.
- Array, mask merge, forwarding and read pipeline stay in the top module.

Test Plan:
- Reset release with ARR_DEPTH=16, READ_LAT=1 -> o_busy=1 for 16 cycles then 0; read of every address returns 0 with o_rvalid one cycle after i_re.
- Write addr 5, data all-lanes 0xAA, mask all 1; then write addr 5, data 0x55, mask 0x1 -> read addr 5 gives lane0=0x55, lanes1..32=0xAA.
- Same cycle: i_we addr 3 data 0x11, mask lanes 0-1, old contents 0x77; i_re addr 3 -> o_rdata lanes0-1=0x11, rest 0x77.
- READ_LAT=2: reads addr 0,1,2 on consecutive cycles -> o_rvalid high on three consecutive cycles starting 2 edges after the first i_re, data in order.
- i_clr asserted in IDLE together with i_we addr 7 -> write dropped; o_busy high 16 cycles; addr 7 reads 0. i_re during busy -> no o_rvalid.
- i_clr re-pulsed at clear cycle 10 -> o_busy extends to 26 cycles total. Reset asserted mid-clear -> o_busy=1, o_rvalid=0 immediately (asynchronous).

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and helpers for the lane-masked SDP RAM.
// Holds default geometry, the clear FSM states and mask expansion.
package ram_pkg;

    localparam int LANES_DEF      = 33;
    localparam int LANE_WIDTH_DEF = 8;
    localparam int ARR_DEPTH_DEF  = 2048;

    // Bounds of the generic mask expander.
    localparam int MAX_LANES  = 64;
    localparam int MAX_LANE_W = 32;
    localparam int MAX_VEC    = MAX_LANES * MAX_LANE_W;
    localparam int LIDX_W     = $clog2(MAX_LANES);
    localparam int BIDX_W     = $clog2(MAX_VEC);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic bit read_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // Expand a lane mask into a per-bit mask of lanes lw bits wide.
    function automatic logic [MAX_VEC-1:0] expand_mask(
        input logic [MAX_LANES-1:0] m,
        input int                   lw
    );
        logic [MAX_VEC-1:0] out;
        int                 l;
        out = '0;
        for (int i = 0; i < MAX_VEC; i++) begin
            l = i / lw;
            if (l < MAX_LANES)
                out[BIDX_W'(i)] = m[LIDX_W'(l)];
        end
        return out;
    endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Sequential clear engine: sweeps the array writing zeros.
// Owns the clear pointer and the busy flag.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int ARR_DEPTH  = ARR_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(ARR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ARR_DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    // State and pointer registers; reset starts a clear sweep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: a clear request (re)starts the sweep at word 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (i_clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (i_clr) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign o_busy     = (state_q == CLEAR);
    assign o_clr_we   = (state_q == CLEAR);
    assign o_clr_addr = ptr_q;

endmodule

// File: rtl/ram_sdp_lanes.sv
// Simple-dual-port vector RAM with per-lane write mask,
// write-first forwarding and a 1- or 2-cycle read pipeline.
module ram_sdp_lanes
    import ram_pkg::*;
#(
    parameter  int LANES      = LANES_DEF,
    parameter  int LANE_WIDTH = LANE_WIDTH_DEF,
    parameter  int ARR_DEPTH  = ARR_DEPTH_DEF,
    parameter  int READ_LAT   = 1,
    localparam int VEC_WIDTH  = LANES * LANE_WIDTH,
    localparam int ADDR_WIDTH = $clog2(ARR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    output logic                  o_busy,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [LANES-1:0]      i_wmask,
    input  logic [VEC_WIDTH-1:0]  i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                  o_rvalid,
    output logic [VEC_WIDTH-1:0]  o_rdata
);

    if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
        $error("READ_LAT must be 1 or 2");
    end
    if (LANES > MAX_LANES || LANE_WIDTH > MAX_LANE_W) begin : g_bad_geom
        $error("lane geometry exceeds mask expander bounds");
    end

    logic [VEC_WIDTH-1:0]  mem [ARR_DEPTH];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [VEC_WIDTH-1:0]  bmask;
    logic [VEC_WIDTH-1:0]  wr_word;
    logic [VEC_WIDTH-1:0]  rd_word;
    logic                  rv1_q;
    logic [VEC_WIDTH-1:0]  rd1_q;

    ram_clr_ctrl #(
        .ARR_DEPTH  (ARR_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .o_busy     (busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    assign o_busy = busy;

    // A clear request in the same cycle drops the user write.
    assign wr_en = i_we & ~busy & ~i_clr;
    assign rd_en = i_re & ~busy;

    assign bmask = VEC_WIDTH'(expand_mask(MAX_LANES'(i_wmask), LANE_WIDTH));

    assign wr_word = (mem[i_waddr] & ~bmask) | (i_wdata & bmask);
    assign rd_word = (wr_en && i_waddr == i_raddr) ? wr_word
                                                   : mem[i_raddr];

    // Array write port, shared by the clear sweep and user writes.
    always_ff @(posedge i_clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_en)
            mem[i_waddr] <= wr_word;
    end

    // First read stage; data holds between accepted reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rv1_q <= 1'b0;
            rd1_q <= '0;
        end else begin
            rv1_q <= rd_en;
            if (rd_en)
                rd1_q <= rd_word;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic                 rv2_q;
        logic [VEC_WIDTH-1:0] rd2_q;

        // Extra output register stage for the two-cycle read.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rv2_q <= 1'b0;
                rd2_q <= '0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q)
                    rd2_q <= rd1_q;
            end
        end

        assign o_rvalid = rv2_q;
        assign o_rdata  = rd2_q;
    end else begin : g_lat1
        assign o_rvalid = rv1_q;
        assign o_rdata  = rd1_q;
    end

endmodule

// File: tb/tb_ram_sdp_lanes.sv
// Bench for ram_sdp_lanes: latency-1 and latency-2 copies share
// stimulus and are compared against an array reference model.
module tb_ram_sdp_lanes;

    localparam int LN  = 33;
    localparam int LW  = 8;
    localparam int VW  = LN * LW;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr   = 1'b0;
    logic          we    = 1'b0;
    logic          re    = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [LN-1:0] wmask = '0;
    logic [VW-1:0] wdata = '0;

    logic          busy1, busy2, rv1, rv2;
    logic [VW-1:0] rd1, rd2;

    ram_sdp_lanes #(
        .LANES (LN), .LANE_WIDTH (LW), .ARR_DEPTH (DEP), .READ_LAT (1)
    ) dut1 (
        .i_clk (clk), .i_rst_n (rst_n), .i_clr (clr), .o_busy (busy1),
        .i_we (we), .i_waddr (waddr), .i_wmask (wmask), .i_wdata (wdata),
        .i_re (re), .i_raddr (raddr), .o_rvalid (rv1), .o_rdata (rd1)
    );

    ram_sdp_lanes #(
        .LANES (LN), .LANE_WIDTH (LW), .ARR_DEPTH (DEP), .READ_LAT (2)
    ) dut2 (
        .i_clk (clk), .i_rst_n (rst_n), .i_clr (clr), .o_busy (busy2),
        .i_we (we), .i_waddr (waddr), .i_wmask (wmask), .i_wdata (wdata),
        .i_re (re), .i_raddr (raddr), .o_rvalid (rv2), .o_rdata (rd2)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] ref_mem [DEP];
    int            busy_left;
    bit            prev_v;
    logic [VW-1:0] prev_d, hold1, hold2;
    int            checks = 0;
    int            fails  = 0;
    int            n;

    task automatic chk(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_clear();
        busy_left = DEP;
        for (int a = 0; a < DEP; a++) ref_mem[a] = '0;
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    // One clock: drive, let the edge pass, update model, check.
    task automatic cycle(input bit c_we, input int wa, input logic [LN-1:0] m,
                         input logic [VW-1:0] wd, input bit c_re,
                         input int ra, input bit c_clr);
        bit            ev;
        logic [VW-1:0] ed;
        we = c_we; waddr = AW'(wa); wmask = m; wdata = wd;
        re = c_re; raddr = AW'(ra); clr = c_clr;
        @(posedge clk);
        #1;
        ev = 1'b0;
        ed = '0;
        if (busy_left == 0) begin
            if (c_we && !c_clr)
                for (int k = 0; k < LN; k++)
                    if (m[k]) ref_mem[wa][k*LW +: LW] = wd[k*LW +: LW];
            if (c_re) begin
                ev = 1'b1;
                ed = ref_mem[ra];
            end
            if (c_clr) start_clear();
        end else if (c_clr) begin
            start_clear();
        end else begin
            busy_left--;
        end
        chk("busy1", VW'(busy1), VW'(busy_left > 0));
        chk("busy2", VW'(busy2), VW'(busy_left > 0));
        chk("rvalid1", VW'(rv1), VW'(ev));
        if (ev) hold1 = ed;
        chk("rdata1", rd1, hold1);
        chk("rvalid2", VW'(rv2), VW'(prev_v));
        if (prev_v) hold2 = prev_d;
        chk("rdata2", rd2, hold2);
        prev_v = ev;
        prev_d = ed;
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        cycle(0, 0, '0, '0, 1, a, 0);
    endtask

    task automatic wr(input int a, input logic [LN-1:0] m,
                      input logic [VW-1:0] d);
        cycle(1, a, m, d, 0, 0, 0);
    endtask

    // Assert reset asynchronously, check at once, release after an edge.
    task automatic do_reset();
        we = 1'b0; re = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy1", VW'(busy1), VW'(1));
        chk("rst_busy2", VW'(busy2), VW'(1));
        chk("rst_rvalid1", VW'(rv1), '0);
        chk("rst_rvalid2", VW'(rv2), '0);
        chk("rst_rdata1", rd1, '0);
        chk("rst_rdata2", rd2, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_clear();
        prev_v = 1'b0;
        prev_d = '0;
        hold1  = '0;
        hold2  = '0;
    endtask

    initial begin
        logic [VW-1:0] aa, ff77;
        aa   = {LN{8'hAA}};
        ff77 = {LN{8'h77}};

        #2;
        do_reset();

        // Busy for DEP cycles; reads during busy are ignored.
        for (int i = 0; i < DEP; i++)
            cycle(0, 0, '0, '0, 1, int'($urandom_range(DEP - 1)), 0);

        for (int a = 0; a < DEP; a++) rd(a);
        idle();

        // Partial-lane overwrite.
        wr(5, '1, aa);
        wr(5, LN'(1), {LN{8'h55}});
        rd(5);
        idle();

        // Same-cycle write/read collision: write-first per lane.
        wr(3, '1, ff77);
        cycle(1, 3, LN'(3), {LN{8'h11}}, 1, 3, 0);
        idle();
        idle();

        // Back-to-back reads for the two-cycle pipeline.
        wr(0, '1, {LN{8'hC0}});
        wr(1, '1, {LN{8'hC1}});
        wr(2, '1, {LN{8'hC2}});
        rd(0); rd(1); rd(2);
        idle(); idle();

        // Clear wins over a same-cycle write.
        wr(7, '1, aa);
        cycle(1, 7, '1, {LN{8'h3C}}, 0, 0, 1);
        for (int i = 0; i < DEP; i++)
            cycle(1, int'($urandom_range(DEP - 1)), '1, rnd_vec(),
                  1, int'($urandom_range(DEP - 1)), 0);
        rd(7);
        idle(); idle();

        // Randomized traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            int wa, ra;
            wa = int'($urandom_range(DEP - 1));
            ra = ($urandom_range(1) == 1) ? wa
                                          : int'($urandom_range(DEP - 1));
            cycle(1'($urandom), wa, LN'({$urandom, $urandom}), rnd_vec(),
                  1'($urandom), ra, ($urandom_range(79) == 0));
        end
        while (busy_left > 0) idle();
        idle(); idle();

        // Re-pulsed clear extends the sweep.
        do_reset();
        n = 0;
        repeat (9) begin idle(); n++; end
        cycle(0, 0, '0, '0, 0, 0, 1);
        n++;
        while (busy1 === 1'b1 && n < 100) begin idle(); n++; end
        chk("busy_len", VW'(n), VW'(26));

        // Reset while a read is in flight aborts it.
        wr(4, '1, aa);
        rd(4);
        #2;
        do_reset();
        for (int i = 0; i < DEP; i++) idle();
        rd(4);
        idle(); idle();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
